affine_interp_filter_6tap: RTL

//  Streaming 6-tap quarter-precision interpolation filter for the affine MC path.

---
 rtl/affine_interp_filter_6tap.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/affine_interp_filter_6tap.sv
// 6-tap quarter-pel interpolation filter for the affine MC path.
// One sample in per handshake; sliding 6-sample window; shift-add coefficient
// products; products -> sum -> round/clip pipeline. A downstream stall freezes
// every register, including the window.

// Per-tap multiplier. All four phase products are built from constant
// shift-add trees, then the active phase selects one.
module aif_tap #(
  parameter int IN_W = 16,
  parameter int TAP  = 0
) (
  input  logic signed [IN_W-1:0] x,
  input  logic        [1:0]      ph,
  output logic signed [IN_W+7:0] p
);
  localparam int PW = IN_W + 8;

  function automatic int coef(input int t, input int f);
    int c;
    c = 0;
    case (t)
      0, 5: case (f) 0: c = 0;  1: c = 1;   2: c = 2;   default: c = 1;   endcase
      1:    case (f) 0: c = 0;  1: c = -8;  2: c = -11; default: c = -3;  endcase
      2:    case (f) 0: c = 64; 1: c = 60;  2: c = 41;  default: c = 13;  endcase
      3:    case (f) 0: c = 0;  1: c = 13;  2: c = 41;  default: c = 60;  endcase
      default: case (f) 0: c = 0; 1: c = -3; 2: c = -11; default: c = -8; endcase
    endcase
    return c;
  endfunction

  // c is an elaboration constant, so this folds to a fixed adder tree.
  function automatic logic signed [PW-1:0] mcm(input logic signed [IN_W-1:0] v, input int c);
    int a;
    logic signed [PW-1:0] xe, acc;
    a   = (c < 0) ? -c : c;
    xe  = PW'(v);
    acc = '0;
    for (int k = 0; k < 7; k++)
      if (a[k]) acc = acc + (xe <<< k);
    return (c < 0) ? -acc : acc;
  endfunction

  logic signed [PW-1:0] pr [4];

  for (genvar f = 0; f < 4; f++) begin : g_ph
    assign pr[f] = mcm(x, coef(TAP, f));
  end

  assign p = pr[ph];
endmodule

module affine_interp_filter_6tap #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 16,
  parameter int SHIFT = 6,
  parameter int CLIP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_row_start,
  input  logic [1:0]       in_phase,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [1:0]       out_phase
);
  localparam int NTAP   = 6;
  localparam int STAGES = 3;
  localparam int PW     = IN_W + 8;
  localparam logic signed [PW-1:0] RND  = (SHIFT == 0) ? PW'(0) : PW'(1 << ((SHIFT > 0) ? SHIFT - 1 : 0));
  localparam logic signed [PW-1:0] MAXV = PW'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [PW-1:0] MINV = PW'(-(1 << (OUT_W - 1)));

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

  state_t                      state, state_nx;
  logic [2:0]                  fill, fill_nx;
  logic [NTAP-1:0][IN_W-1:0]   win;
  logic [1:0]                  phase_r;
  logic [STAGES:0]             vld_pipe;
  logic [STAGES:1][1:0]        ph_pipe;
  logic [NTAP-1:0][PW-1:0]     prod, prod_r;
  logic signed [PW-1:0]        sum, sum_r, rnd_y;
  logic [OUT_W-1:0]            y_out;
  logic                        stall, adv, in_fire, win_fire;

  assign stall     = out_valid & ~out_ready;
  assign adv       = ~stall;
  assign in_ready  = ~stall;
  assign in_fire   = in_valid & in_ready;
  assign out_valid = vld_pipe[STAGES];
  assign out_phase = ph_pipe[STAGES];

  // Fill tracking: IDLE until the first row_start, FILL while the window is short, RUN after.
  always_comb begin
    state_nx = state;
    fill_nx  = fill;
    win_fire = 1'b0;
    if (in_fire) begin
      if (in_row_start) begin
        state_nx = FILL;
        fill_nx  = 3'd1;
      end else begin
        case (state)
          FILL: begin
            fill_nx = fill + 3'd1;
            if (fill == 3'd5) begin
              state_nx = RUN;
              win_fire = 1'b1;
            end
          end
          RUN:     win_fire = 1'b1;
          default: ;
        endcase
      end
    end
  end

  // Window, phase and fill registers; row_start clears the window before the shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      fill    <= 3'd0;
      phase_r <= 2'd0;
      win     <= '0;
    end else begin
      state <= state_nx;
      fill  <= fill_nx;
      if (in_fire && in_row_start) begin
        phase_r <= in_phase;
        win     <= {in_data, {((NTAP-1)*IN_W){1'b0}}};
      end else if (in_fire && state != IDLE) begin
        win <= {in_data, win[NTAP-1:1]};
      end
    end
  end

  for (genvar i = 0; i < NTAP; i++) begin : g_tap
    aif_tap #(.IN_W(IN_W), .TAP(i)) u_tap (
      .x (win[i]),
      .ph(phase_r),
      .p (prod[i])
    );
  end

  // Adder over the registered products.
  always_comb begin
    sum = '0;
    for (int i = 0; i < NTAP; i++) sum = sum + $signed(prod_r[i]);
  end

  assign rnd_y = (sum_r + RND) >>> SHIFT;

  // Saturate or wrap the normalised result to the output width.
  always_comb begin
    y_out = rnd_y[OUT_W-1:0];
    if (CLIP != 0) begin
      if (rnd_y > MAXV)      y_out = MAXV[OUT_W-1:0];
      else if (rnd_y < MINV) y_out = MINV[OUT_W-1:0];
    end
  end

  // Products/sum/output pipeline; phase travels with valid, all frozen on stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      ph_pipe  <= '0;
      prod_r   <= '0;
      sum_r    <= '0;
      out_data <= '0;
    end else if (adv) begin
      vld_pipe[0]          <= win_fire;
      vld_pipe[STAGES:1]   <= vld_pipe[STAGES-1:0];
      ph_pipe[1]           <= phase_r;
      ph_pipe[STAGES:2]    <= ph_pipe[STAGES-1:1];
      prod_r               <= prod;
      sum_r                <= sum;
      out_data             <= y_out;
    end
  end
endmodule
